// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset init window, load-use bubble,
// mispredict flush and data-memory back-pressure with timeout. Macro PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_memread,
  input  logic             i_ex_mispred,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_stall,
  output logic             o_idex_flush,
  output logic             o_exmem_stall,
  output logic             o_exmem_flush,
  output logic             o_memwb_stall,
  output logic             o_memwb_flush,
  output logic [1:0]       o_state,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_LDUSE   = 2'd3
  } state_t;

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

  state_t        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic          loaduse, memwait;

  assign loaduse = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0) &
                   ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                    (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));
  assign memwait = i_mem_req & ~i_mem_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    o_pc_stall    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_stall  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_stall = 1'b0;
    o_exmem_flush = 1'b0;
    o_memwb_flush = 1'b0;
    case (state_q)
      S_INIT: begin
        o_pc_stall    = 1'b1;
        o_ifid_flush  = 1'b1;
        o_idex_flush  = 1'b1;
        o_exmem_flush = 1'b1;
        o_memwb_flush = 1'b1;
        init_cnt_d    = init_cnt_q + IW'(1);
        if (init_cnt_q == INIT_LAST) state_d = S_RUN;
      end
      S_MEMWAIT: begin
        if (memwait) begin
          o_pc_stall    = 1'b1;
          o_ifid_stall  = 1'b1;
          o_idex_stall  = 1'b1;
          o_exmem_stall = 1'b1;
          o_memwb_flush = 1'b1;
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WW'(1);
        end else begin
          // Release cycle: a mispredict held frozen in EX is honoured now.
          wait_cnt_d = '0;
          state_d    = S_RUN;
          if (i_ex_mispred) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
          end
        end
      end
      default: begin
        if (memwait) begin
          o_pc_stall    = 1'b1;
          o_ifid_stall  = 1'b1;
          o_idex_stall  = 1'b1;
          o_exmem_stall = 1'b1;
          o_memwb_flush = 1'b1;
          wait_cnt_d    = WW'(1);
          state_d       = S_MEMWAIT;
        end else if (i_ex_mispred) begin
          o_ifid_flush = 1'b1;
          o_idex_flush = 1'b1;
          state_d      = S_RUN;
        end else if (loaduse && state_q == S_RUN) begin
          o_pc_stall   = 1'b1;
          o_ifid_stall = 1'b1;
          o_idex_flush = 1'b1;
          state_d      = S_LDUSE;
        end else begin
          state_d = S_RUN;
        end
      end
    endcase
    timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
  end

  assign o_memwb_stall = 1'b0;
  assign o_state       = state_q;
  assign o_mem_timeout = timeout_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             flush_evt;

  assign flush_evt = (state_q != S_INIT) & ~memwait & i_ex_mispred;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q != S_INIT && o_pc_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a history-based behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int INIT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  // {pc, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, exmem_fl, memwb_st, memwb_fl}
  localparam logic [8:0] P_NONE = 9'b0_00_00_00_00;
  localparam logic [8:0] P_INIT = 9'b1_01_01_01_01;
  localparam logic [8:0] P_MW   = 9'b1_10_10_10_01;
  localparam logic [8:0] P_MISP = 9'b0_01_01_00_00;
  localparam logic [8:0] P_LU   = 9'b1_10_01_00_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, ex_rd = '0;
  logic use1 = 0, use2 = 0, ex_valid = 0, ex_memread = 0, mispred = 0, mem_req = 0, mem_ready = 0;
  logic pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, exmem_fl, memwb_st, memwb_fl;
  logic [1:0] state;
  logic timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] outs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_memread(ex_memread), .i_ex_mispred(mispred),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_stall(pc_st), .o_ifid_stall(ifid_st), .o_ifid_flush(ifid_fl),
    .o_idex_stall(idex_st), .o_idex_flush(idex_fl),
    .o_exmem_stall(exmem_st), .o_exmem_flush(exmem_fl),
    .o_memwb_stall(memwb_st), .o_memwb_flush(memwb_fl),
    .o_state(state), .o_mem_timeout(timeout),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  assign outs = {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, exmem_fl, memwb_st, memwb_fl};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] perf(input logic [CNT_W-1:0] v);
`ifdef PERF_CNT_EN
    return v;
`else
    return '0;
`endif
  endfunction

  // Model: state is inferred from history (cycles since reset, last cycle's action).
  int               m_valid = 0;
  int               m_cyc;
  bit               m_waiting, m_bubble, m_timeout;
  int               m_wait_len;
  logic [CNT_W-1:0] m_stall, m_flush;
  bit               lu, mw, in_init, misp_fire, lu_fire;
  logic [8:0]       exp_outs;
  logic [1:0]       exp_state;

  always begin
    @(negedge clk);
    if (m_valid != 0) begin
      lu = ex_valid && ex_memread && ex_rd != 0 &&
           ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
      mw = mem_req && !mem_ready;
      in_init = m_cyc < INIT_CYCLES;
      misp_fire = 0;
      lu_fire = 0;
      if (in_init) exp_outs = P_INIT;
      else if (mw) exp_outs = P_MW;
      else if (mispred) begin exp_outs = P_MISP; misp_fire = 1; end
      else if (lu && !m_waiting && !m_bubble) begin exp_outs = P_LU; lu_fire = 1; end
      else exp_outs = P_NONE;
      exp_state = in_init ? 2'd0 : m_waiting ? 2'd2 : m_bubble ? 2'd3 : 2'd1;
      chk("outs", 64'(outs), 64'(exp_outs));
      chk("state", 64'(state), 64'(exp_state));
      chk("timeout", 64'(timeout), 64'(m_timeout));
      chk("stall_cnt", 64'(stall_cnt), 64'(perf(m_stall)));
      chk("flush_cnt", 64'(flush_cnt), 64'(perf(m_flush)));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1;
      m_cyc = 0;
      m_waiting = 0;
      m_bubble = 0;
      m_timeout = 0;
      m_wait_len = 0;
      m_stall = '0;
      m_flush = '0;
    end else if (m_valid != 0) begin
      if (!in_init && exp_outs[8]) m_stall = m_stall + 1'b1;
      if (misp_fire) m_flush = m_flush + 1'b1;
      m_waiting = !in_init && mw;
      m_wait_len = m_waiting ? ((m_wait_len + 1 > MEM_TIMEOUT) ? MEM_TIMEOUT : m_wait_len + 1) : 0;
      if (m_wait_len == MEM_TIMEOUT) m_timeout = 1;
      m_bubble = lu_fire;
      if (m_cyc < 1000) m_cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs1 = 0; rs2 = 0; ex_rd = 0; use1 = 0; use2 = 0;
    ex_valid = 0; ex_memread = 0; mispred = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_lu();
    ex_valid = 1; ex_memread = 1; ex_rd = 5; rs1 = 5; use1 = 1;
  endtask

  initial begin
    int hold;
    hold = 0;
    step(); step();
    rst_n = 1;
    @(negedge clk); chk("init0_state", 64'(state), 0); chk("init0_outs", 64'(outs), 64'(P_INIT));
    step();
    @(negedge clk); chk("init1_state", 64'(state), 0); chk("init1_outs", 64'(outs), 64'(P_INIT));
    step();
    @(negedge clk); chk("run_state", 64'(state), 1); chk("run_outs", 64'(outs), 0);

    step(); set_lu();
    @(negedge clk); chk("lu_outs", 64'(outs), 64'(P_LU));
    step();
    @(negedge clk); chk("lu_state", 64'(state), 3); chk("lu_after", 64'(outs), 0);
    step(); ex_rd = 0; rs1 = 0;
    @(negedge clk); chk("rd0_outs", 64'(outs), 0); chk("rd0_state", 64'(state), 1);

    step(); clear_in(); mem_req = 1;
    @(negedge clk); chk("mw0_outs", 64'(outs), 64'(P_MW));
    step();
    @(negedge clk); chk("mw1_outs", 64'(outs), 64'(P_MW)); chk("mw1_state", 64'(state), 2);
    step();
    @(negedge clk); chk("mw2_outs", 64'(outs), 64'(P_MW));
    step(); mem_ready = 1;
    @(negedge clk); chk("mw_rel_outs", 64'(outs), 0); chk("mw_rel_state", 64'(state), 2);
    chk("mw_rel_tmo", 64'(timeout), 0);
    step(); clear_in();
    @(negedge clk); chk("mw_stall_cnt", 64'(stall_cnt), 64'(perf(4)));

    step(); mem_req = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("tmo_seq", 64'(timeout), (k == 4) ? 1 : 0);
      chk("tmo_outs", 64'(outs), 64'(P_MW));
      step();
    end
    mem_ready = 1;
    @(negedge clk); chk("tmo_rel_outs", 64'(outs), 0); chk("tmo_sticky", 64'(timeout), 1);
    step(); clear_in();
    @(negedge clk); chk("tmo_sticky2", 64'(timeout), 1);

    step(); set_lu(); mispred = 1;
    @(negedge clk); chk("misp_lu_outs", 64'(outs), 64'(P_MISP));
    step(); clear_in();
    @(negedge clk); chk("misp_flush_cnt", 64'(flush_cnt), 64'(perf(1))); chk("misp_state", 64'(state), 1);

    step(); mem_req = 1; mispred = 1;
    @(negedge clk); chk("mwm0_outs", 64'(outs), 64'(P_MW));
    step();
    @(negedge clk); chk("mwm1_outs", 64'(outs), 64'(P_MW));
    step(); mem_ready = 1;
    @(negedge clk); chk("mwm_rel_outs", 64'(outs), 64'(P_MISP));
    step(); clear_in();
    @(negedge clk); chk("mwm_flush_cnt", 64'(flush_cnt), 64'(perf(2))); chk("mwm_state", 64'(state), 1);

    step(); rst_n = 0;
    step();
    @(negedge clk); chk("rst_tmo", 64'(timeout), 0); chk("rst_state", 64'(state), 0);
    chk("rst_stall_cnt", 64'(stall_cnt), 0);
    step(); rst_n = 1;

    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = ($urandom_range(0, 249) != 0);
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      use1 = 1'($urandom);
      use2 = 1'($urandom);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_memread = 1'($urandom);
      mispred = ($urandom_range(0, 7) == 0);
      if (hold == 0 && $urandom_range(0, 29) == 0) hold = $urandom_range(2, 7);
      if (hold > 0) begin
        hold--;
        mem_req = 1;
        mem_ready = 0;
      end else begin
        mem_req = 1'($urandom);
        mem_ready = ($urandom_range(0, 9) < 7);
      end
    end
    step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
